// File: rtl/perf_counter_bank.sv
// Programmable performance counter bank: per-counter event select, wrap/saturate,
// global freeze, atomic snapshot, sticky overflow with masked interrupt, 1-cycle read port.
module perf_counter_bank #(
  parameter int NUM_COUNTERS  = 8,
  parameter int COUNTER_WIDTH = 32,
  parameter int NUM_EVENTS    = 16,
  parameter int INC_WIDTH     = 3,
  parameter int IDX_W         = $clog2(NUM_COUNTERS),
  parameter int EVT_W         = $clog2(NUM_EVENTS)
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0] eventInc,
  input  logic                            freeze,
  input  logic                            cfgWe,
  input  logic [IDX_W-1:0]                cfgIndex,
  input  logic                            cfgEnable,
  input  logic                            cfgSaturate,
  input  logic [EVT_W-1:0]                cfgEventSel,
  input  logic [NUM_COUNTERS-1:0]         clearReq,
  input  logic                            snapshotReq,
  input  logic                            rdReq,
  input  logic [IDX_W-1:0]                rdIndex,
  input  logic                            rdFromSnapshot,
  output logic                            rdValid,
  output logic [COUNTER_WIDTH-1:0]        rdData,
  output logic [NUM_COUNTERS-1:0]         overflow,
  output logic                            overflowIrq,
  input  logic [NUM_COUNTERS-1:0]         irqMask
);

  localparam logic [COUNTER_WIDTH-1:0] ALL_ONES  = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] ALL_ZEROS = {COUNTER_WIDTH{1'b0}};

  logic [INC_WIDTH-1:0]     ev_inc_s [NUM_EVENTS];
  logic [INC_WIDTH-1:0]     inc_s    [NUM_COUNTERS];
  logic [COUNTER_WIDTH:0]   sum_s    [NUM_COUNTERS];

  logic [COUNTER_WIDTH-1:0] cnt_q  [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] cnt_d  [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] snap_q [NUM_COUNTERS];
  logic [COUNTER_WIDTH-1:0] snap_d [NUM_COUNTERS];
  logic [EVT_W-1:0]         sel_q  [NUM_COUNTERS];
  logic [EVT_W-1:0]         sel_d  [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0]  en_q, en_d;
  logic [NUM_COUNTERS-1:0]  sat_q, sat_d;
  logic [NUM_COUNTERS-1:0]  ovf_q, ovf_d;
  logic                     irq_q, irq_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [COUNTER_WIDTH-1:0] rd_data_q, rd_data_d;

  // Unpack the flat event bus into one increment per event source.
  always_comb begin
    for (int e = 0; e < NUM_EVENTS; e++) begin
      ev_inc_s[e] = eventInc[e*INC_WIDTH +: INC_WIDTH];
    end
  end

  // Per-counter increment, wrap/saturate arithmetic, clear priority and sticky overflow.
  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      inc_s[i] = {INC_WIDTH{1'b0}};
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (en_q[i] && !freeze && !clearReq[i] && (int'(sel_q[i]) < NUM_EVENTS)) begin
        inc_s[i] = ev_inc_s[sel_q[i]];
      end else begin
        inc_s[i] = {INC_WIDTH{1'b0}};
      end
      sum_s[i] = {1'b0, cnt_q[i]} + {{(COUNTER_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_s[i]};
      if (clearReq[i]) begin
        cnt_d[i] = ALL_ZEROS;
        ovf_d[i] = 1'b0;
      end else if (sum_s[i][COUNTER_WIDTH]) begin
        // A saturated counter receiving any increment lands here too and re-flags.
        cnt_d[i] = sat_q[i] ? ALL_ONES : sum_s[i][COUNTER_WIDTH-1:0];
        ovf_d[i] = 1'b1;
      end else begin
        cnt_d[i] = sum_s[i][COUNTER_WIDTH-1:0];
      end
    end
  end

  // Configuration update; out-of-range indices are dropped.
  always_comb begin
    en_d  = en_q;
    sat_d = sat_q;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      sel_d[i] = sel_q[i];
    end
    if (cfgWe && (int'(cfgIndex) < NUM_COUNTERS)) begin
      en_d[cfgIndex]  = cfgEnable;
      sat_d[cfgIndex] = cfgSaturate;
      sel_d[cfgIndex] = cfgEventSel;
    end else begin
      en_d = en_q;
    end
  end

  // Snapshot captures pre-edge live values for every counter at once.
  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (snapshotReq) begin
        snap_d[i] = cnt_q[i];
      end else begin
        snap_d[i] = snap_q[i];
      end
    end
  end

  // Read port and interrupt; both observe pre-edge state.
  always_comb begin
    rd_valid_d = rdReq;
    rd_data_d  = rd_data_q;
    irq_d      = |(ovf_q & irqMask);
    if (rdReq) begin
      if (int'(rdIndex) < NUM_COUNTERS) begin
        rd_data_d = rdFromSnapshot ? snap_q[rdIndex] : cnt_q[rdIndex];
      end else begin
        rd_data_d = ALL_ZEROS;
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i]  <= ALL_ZEROS;
        snap_q[i] <= ALL_ZEROS;
        sel_q[i]  <= {EVT_W{1'b0}};
      end
      en_q       <= {NUM_COUNTERS{1'b0}};
      sat_q      <= {NUM_COUNTERS{1'b0}};
      ovf_q      <= {NUM_COUNTERS{1'b0}};
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= ALL_ZEROS;
    end else begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        snap_q[i] <= snap_d[i];
        sel_q[i]  <= sel_d[i];
      end
      en_q       <= en_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rdValid     = rd_valid_q;
  assign rdData      = rd_data_q;
  assign overflow    = ovf_q;
  assign overflowIrq = irq_q;

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised hardware performance-monitoring counter bank that replaces the fixed set of perf counters with a bank of NUM_COUNTERS programmable counters. Each counter selects one of NUM_EVENTS weighted event sources (IC miss, load miss, branch mispredict, commits, ...). Counters support wrap or saturate mode, a global freeze, atomic snapshot and overflow reporting. The bank sits beside the commit stage and feeds the debug/CSR read path.

Parameters:
NUM_COUNTERS, 8, number of counters
COUNTER_WIDTH, 32, bits per counter
NUM_EVENTS, 16, number of event sources
INC_WIDTH, 3, bits of per-cycle increment per event (max increment 7)
IDX_W, $clog2(NUM_COUNTERS), counter index width (derived)
EVT_W, $clog2(NUM_EVENTS), event select width (derived)

Ports:
clk  in  1  clock
rstN  in  1  reset, asynchronous, active-low
eventInc  in  NUM_EVENTS*INC_WIDTH  per-event increment this cycle; event e occupies bits [e*INC_WIDTH +: INC_WIDTH]
freeze  in  1  global hold; blocks all increments while high
cfgWe  in  1  configuration write strobe
cfgIndex  in  IDX_W  counter being configured
cfgEnable  in  1  counter enable
cfgSaturate  in  1  1 = saturate, 0 = wrap
cfgEventSel  in  EVT_W  event source select
clearReq  in  NUM_COUNTERS  per-counter clear, one bit per counter
snapshotReq  in  1  copy all live counters into the snapshot bank
rdReq  in  1  read request
rdIndex  in  IDX_W  counter to read
rdFromSnapshot  in  1  1 = read the snapshot bank, 0 = read the live counter
rdValid  out  1  read data valid
rdData  out  COUNTER_WIDTH  read data
overflow  out  NUM_COUNTERS  sticky overflow flags
overflowIrq  out  1  registered OR of (overflow & irqMask)
irqMask  in  NUM_COUNTERS  interrupt mask

Behaviour:
- Reset (rstN low, asynchronous):
  - all live and snapshot counters = 0
  - per counter: enable = 0, saturate = 0, eventSel = 0
  - overflow = 0, overflowIrq = 0, rdValid = 0, rdData = 0
  - Reset asserted mid-operation discards pending reads and increments immediately.
- Increment, per counter i, each rising edge:
  - inc = zero-extended eventInc[eventSel_i] when enable_i && !freeze && !clearReq[i]; otherwise 0.
  - sum is computed at COUNTER_WIDTH+1 bits.
- Wrap mode: counter = sum mod 2^COUNTER_WIDTH. overflow[i] sets when sum[COUNTER_WIDTH] = 1.
- Saturate mode:
  - If sum exceeds all-ones, the counter holds at all-ones and overflow[i] sets.
  - If the counter is already all-ones and inc > 0, overflow[i] sets again (it is already 1).
- Clear:
  - clearReq[i] sets counter i to 0 and clears overflow[i] on the next edge.
  - Clear beats a same-cycle increment: the increment is dropped.
  - Clear works during freeze.
- overflow flags are sticky; only clearReq or reset clears them.
- Config write:
  - cfgWe updates the config of cfgIndex at the edge.
  - A same-cycle increment uses the old config. The new config applies from the next cycle.
  - Changing eventSel or saturate does not modify the counter value.
  - cfgIndex >= NUM_COUNTERS is ignored.
- Snapshot:
  - snapshotReq copies every live counter's pre-edge value (before this cycle's increment or clear) into the snapshot bank, all counters in the same cycle.
  - The snapshot bank is otherwise unchanged, including by clearReq.
- Read:
  - 1-cycle latency: rdReq at cycle t gives rdValid = 1 with rdData at t+1.
  - rdData is the value held before edge t, so it excludes increments, clears and snapshots taken in cycle t.
  - rdValid = 0 when no request was made the previous cycle; rdData then holds its last value.
  - Back-to-back reads are accepted every cycle; no stall and no backpressure.
  - rdIndex >= NUM_COUNTERS returns 0 with rdValid = 1.
- overflowIrq is registered: it reflects (overflow & irqMask) != 0 one cycle after an overflow flag sets.
- freeze also holds the overflow flags, since no increments occur.
- eventInc bits for an unselected event are ignored. Counters sharing the same event count independently.

Test Plan:
- Reset, then configure ctr0 (enable, wrap, event 2); hold eventInc[2] = 3 for 4 cycles; read ctr0 -> rdValid one cycle later with rdData = 12, overflow = 0.
- COUNTER_WIDTH = 8 build: ctr1 in wrap mode preloaded to 254 via increments, add 5 -> rdData = 3, overflow[1] = 1, overflowIrq = 1 one cycle later with irqMask[1] = 1 (and 0 with the mask clear).
- Same build, ctr2 in saturate mode at 250, add 7 twice -> 255, overflow[2] = 1. A following clearReq[2] together with inc = 7 -> counter 0, overflow[2] = 0.
- snapshotReq in the same cycle as inc = 4 on ctr0 holding 10 -> snapshot read = 10, live read = 14. A later clearReq[0] leaves the snapshot at 10.
- freeze high for 5 cycles with eventInc active -> all counters unchanged; clearReq issued during freeze still zeroes its target.
- cfgWe switching ctr3 from event 1 to event 4 in a cycle with inc1 = 2 and inc4 = 5 -> +2 that cycle, +5 the next cycle. Then assert rstN low mid-read -> rdValid = 0 and all counters = 0 immediately.
